// File: rtl/power_seq_pkg.sv
// rtl/power_seq_pkg.sv - shared state enum, operand field layout and FIFO entry type for the power operand sequencer
package power_seq_pkg;

  localparam int FIELD_W = 8;
  localparam int I_LSB   = 16;
  localparam int IT_LSB  = 8;
  localparam int N_LSB   = 0;
  localparam int ENTRY_W = 3 * FIELD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [FIELD_W-1:0] i;
    logic [FIELD_W-1:0] it;
    logic [FIELD_W-1:0] n;
  } operand_t;

  // Places each field at its fixed calculator offset, independent of struct order.
  function automatic logic [ENTRY_W-1:0] pack_operand(input operand_t op);
    logic [ENTRY_W-1:0] f;
    f = '0;
    f[I_LSB  +: FIELD_W] = op.i;
    f[IT_LSB +: FIELD_W] = op.it;
    f[N_LSB  +: FIELD_W] = op.n;
    return f;
  endfunction

endpackage

// File: rtl/power_seq_fifo.sv
// rtl/power_seq_fifo.sv - synchronous operand FIFO, power-of-two depth, first-word-fall-through head
module power_seq_fifo
  import power_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  operand_t               push_data,
  input  logic                   pop,
  output operand_t               head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  operand_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign push_ok = push && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy next-state; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/power_operand_sequencer.sv
// rtl/power_operand_sequencer.sv - buffers operand triples and dispatches them to the power calculator; optional POWER_SEQ_ZERO_BYPASS_EN
module power_operand_sequencer
  import power_seq_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SCALAR_SIZE  = 24,
  parameter int FIFO_DEPTH   = 4,
  parameter int CALC_LATENCY = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FIELD_W-1:0]          in_i,
  input  logic [FIELD_W-1:0]          in_it,
  input  logic [FIELD_W-1:0]          in_n,
  output logic [SCALAR_SIZE-1:0]      scalar_field,
  input  logic [WIDTH-1:0]            calc_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_result,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int LAT_W = (CALC_LATENCY > 1) ? $clog2(CALC_LATENCY) : 1;

  seq_state_e             state_q, state_d;
  logic [LAT_W-1:0]       cnt_q, cnt_d;
  logic [SCALAR_SIZE-1:0] scalar_q, scalar_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   valid_q, valid_d;
  logic                   push, pop, bypass_head;
  operand_t               in_op, head;
  logic [CNT_W-1:0]       count;

  assign in_op    = '{i: in_i, it: in_it, n: in_n};
  assign in_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;

  power_seq_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(in_op),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

`ifdef POWER_SEQ_ZERO_BYPASS_EN
  // x**0 is always 1, so a zero exponent never needs the calculator.
  assign bypass_head = (head.n == '0);
`else
  assign bypass_head = 1'b0;
`endif

  // Dispatch FSM: pop in IDLE, count down the calculator latency in WAIT, hold the result in HOLD.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scalar_d = scalar_q;
    result_d = result_q;
    valid_d  = valid_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (bypass_head) begin
            result_d = WIDTH'(1);
            valid_d  = 1'b1;
            state_d  = HOLD;
          end else begin
            scalar_d = SCALAR_SIZE'(pack_operand(head));
            cnt_d    = LAT_W'(CALC_LATENCY - 1);
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          result_d = calc_result;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, latency counter and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      scalar_q <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scalar_q <= scalar_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign scalar_field = scalar_q;
  assign out_result   = result_q;
  assign out_valid    = valid_q;
  assign busy         = (state_q != IDLE);
  assign fifo_count   = count;

endmodule
